// File: rtl/fxdpt_result_bypass.sv
// Execute-result bypass network: two forwarding stages (EX/MEM, MEM/WB) feeding operand fetch.
// Define FXDPT_BYPASS_WB_STAGE_EN with DEPTH_WB=1 to add a third (writeback) stage.
module fxdpt_result_bypass #(
  parameter int DEPTH_WB = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  input  logic [4:0]  res_dest,
  input  logic [31:0] res_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  opa_reg,
  input  logic [4:0]  opb_reg,
  input  logic [31:0] opa_rf,
  input  logic [31:0] opb_rf,
  output logic [31:0] opa_fwd,
  output logic [31:0] opb_fwd,
  output logic        opa_hit,
  output logic        opb_hit,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [15:0] fwd_count
);

`ifdef FXDPT_BYPASS_WB_STAGE_EN
  localparam int NST = (DEPTH_WB == 1) ? 3 : 2;
`else
  // DEPTH_WB has no effect unless the writeback stage is compiled in.
  localparam int NST = 2 + 0 * DEPTH_WB;
`endif

  logic        stg_valid_q [NST];
  logic [4:0]  stg_dest_q  [NST];
  logic [31:0] stg_data_q  [NST];
  logic        stg_valid_d [NST];
  logic [4:0]  stg_dest_d  [NST];
  logic [31:0] stg_data_d  [NST];
  logic [15:0] cnt_q, cnt_d;

  logic [4:0]  op_reg [2];
  logic [31:0] op_rf  [2];
  logic [31:0] op_fwd [2];
  logic        op_hit [2];
  logic        inp_fwd_en;

  assign inp_fwd_en = res_valid & ~flush;

  // Stage 0 captures the execute result; flush kills only its valid bit.
  always_comb begin
    stg_valid_d[0] = stg_valid_q[0];
    stg_dest_d[0]  = stg_dest_q[0];
    stg_data_d[0]  = stg_data_q[0];
    if (flush) begin
      stg_valid_d[0] = 1'b0;
    end else if (!stall) begin
      stg_valid_d[0] = res_valid;
      stg_dest_d[0]  = res_dest;
      stg_data_d[0]  = res_data;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NST; gi++) begin : g_shift
      always_comb begin
        stg_valid_d[gi] = stg_valid_q[gi];
        stg_dest_d[gi]  = stg_dest_q[gi];
        stg_data_d[gi]  = stg_data_q[gi];
        if (!stall) begin
          stg_valid_d[gi] = stg_valid_q[gi-1];
          stg_dest_d[gi]  = stg_dest_q[gi-1];
          stg_data_d[gi]  = stg_data_q[gi-1];
        end
      end
    end

    for (gi = 0; gi < NST; gi++) begin : g_stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stg_valid_q[gi] <= 1'b0;
          stg_dest_q[gi]  <= 5'd0;
          stg_data_q[gi]  <= 32'd0;
        end else begin
          stg_valid_q[gi] <= stg_valid_d[gi];
          stg_dest_q[gi]  <= stg_dest_d[gi];
          stg_data_q[gi]  <= stg_data_d[gi];
        end
      end
    end
  endgenerate

  assign op_reg[0] = opa_reg;
  assign op_reg[1] = opb_reg;
  assign op_rf[0]  = opa_rf;
  assign op_rf[1]  = opb_rf;

  // Scan from the oldest stage to the live input so the youngest match wins.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      always_comb begin
        op_fwd[gi] = op_rf[gi];
        op_hit[gi] = 1'b0;
        for (int k = NST - 1; k >= 0; k--) begin
          if (stg_valid_q[k] && (stg_dest_q[k] == op_reg[gi])) begin
            op_fwd[gi] = stg_data_q[k];
            op_hit[gi] = 1'b1;
          end
        end
        if (inp_fwd_en && (res_dest == op_reg[gi])) begin
          op_fwd[gi] = res_data;
          op_hit[gi] = 1'b1;
        end
      end
    end
  endgenerate

  assign opa_fwd = op_fwd[0];
  assign opb_fwd = op_fwd[1];
  assign opa_hit = op_hit[0];
  assign opb_hit = op_hit[1];

  always_comb begin
    cnt_d = cnt_q;
    if ((op_hit[0] || op_hit[1]) && !stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fwd_count = cnt_q;
  assign wb_valid  = stg_valid_q[NST-1] & ~stall;
  assign wb_dest   = stg_dest_q[NST-1];
  assign wb_data   = stg_data_q[NST-1];

endmodule
